imem_loader: RTL and testbench

- Program loader upstream of the pipelined CPU core.
- Receives a byte stream and packs every 4 bytes into a 32-bit instruction word.
- Writes the words to instruction memory through its write port, starting at address 0.
- Holds the CPU off (LD_cpu_hold) while a program is being loaded, then reports done or error.

---
 rtl/imem_loader.sv | 186 ++++++++++++++++++
 tb/tb_imem_loader.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream program loader: packs 4 bytes per word and writes them into IMEM from address 0.
// Define LD_CHECKSUM_EN to add a trailing XOR checksum byte that is verified before completion.
module imem_loader #(
  parameter int ADDR_W     = 8,
  parameter int TIMEOUT    = 1023,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              SYS_clk,
  input  logic              SYS_reset,
  input  logic              LD_start,
  input  logic [ADDR_W-1:0] LD_word_count,
  input  logic              LD_byte_valid,
  input  logic [7:0]        LD_byte,
  output logic              LD_byte_ready,
  output logic [31:0]       IMEM_address,
  output logic [31:0]       IMEM_data,
  output logic              IMEM_wren,
  output logic              LD_busy,
  output logic              LD_cpu_hold,
  output logic              LD_done,
  output logic              LD_error,
  output logic [ADDR_W-1:0] LD_words_loaded
);

  localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
`ifdef LD_CHECKSUM_EN
    CHECK,
`endif
    DONE,
    ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] words_q, words_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       word_q, word_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
`ifdef LD_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic              xfer;
  logic [ADDR_W-1:0] words_inc;

  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      state_q <= IDLE;
      count_q <= '0;
      addr_q  <= '0;
      words_q <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      tmo_q   <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef LD_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      tmo_q   <= tmo_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
`ifdef LD_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

`ifdef LD_CHECKSUM_EN
  assign LD_byte_ready = (state_q == RECV) || (state_q == CHECK);
  assign LD_busy       = (state_q == RECV) || (state_q == WRITE) || (state_q == CHECK);
`else
  assign LD_byte_ready = (state_q == RECV);
  assign LD_busy       = (state_q == RECV) || (state_q == WRITE);
`endif

  assign xfer            = LD_byte_valid && LD_byte_ready;
  assign words_inc       = words_q + 1'b1;
  assign IMEM_wren       = (state_q == WRITE);
  assign IMEM_address    = 32'(addr_q);
  assign IMEM_data       = word_q;
  assign LD_cpu_hold     = hold_q;
  assign LD_done         = done_q;
  assign LD_error        = (state_q == ERROR);
  assign LD_words_loaded = words_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    words_d = words_q;
    idx_d   = idx_q;
    word_d  = word_q;
    tmo_d   = tmo_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
`ifdef LD_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      IDLE, DONE, ERROR: begin
        // CPU is released the cycle after the done pulse
        if (state_q == DONE && done_q) hold_d = 1'b0;
        if (LD_start) begin
          count_d = LD_word_count;
          addr_d  = '0;
          words_d = '0;
          idx_d   = '0;
          tmo_d   = '0;
          hold_d  = 1'b1;
`ifdef LD_CHECKSUM_EN
          csum_d  = '0;
`endif
          if (LD_word_count == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RECV;
          end
        end
      end
      RECV: begin
        if (xfer) begin
          word_d = BIG_ENDIAN ? {word_q[23:0], LD_byte} : {LD_byte, word_q[31:8]};
          idx_d  = idx_q + 2'd1;
          tmo_d  = '0;
`ifdef LD_CHECKSUM_EN
          csum_d = csum_q ^ LD_byte;
`endif
          if (idx_q == 2'd3) state_d = WRITE;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (TIMEOUT != 0 && tmo_q == TMO_LAST) state_d = ERROR;
        end
      end
      WRITE: begin
        addr_d  = addr_q + 1'b1;
        words_d = words_inc;
        tmo_d   = '0;
        if (words_inc == count_q) begin
`ifdef LD_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
          done_d  = 1'b1;
`endif
        end else begin
          state_d = RECV;
        end
      end
`ifdef LD_CHECKSUM_EN
      CHECK: begin
        if (xfer) begin
          if (LD_byte == csum_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ERROR;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (TIMEOUT != 0 && tmo_q == TMO_LAST) state_d = ERROR;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a big-endian instance (TIMEOUT=8) and a little-endian
// instance share one stimulus stream; IMEM writes are logged on the falling edge.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  count = '0;
  logic        valid = 1'b0;
  logic [7:0]  bdata = '0;

  logic        ready, wren, busy, hold, done, err;
  logic [31:0] addr, data;
  logic [7:0]  wl;
  logic        le_ready, le_wren, le_busy, le_hold, le_done, le_err;
  logic [31:0] le_addr, le_data;
  logic [7:0]  le_wl;

  int checks = 0;
  int errors = 0;
  int rdy_in_write = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [31:0] le_wr_data[$];

  imem_loader #(.ADDR_W(8), .TIMEOUT(8), .BIG_ENDIAN(1'b1)) dut (
    .SYS_clk(clk), .SYS_reset(rst), .LD_start(start), .LD_word_count(count),
    .LD_byte_valid(valid), .LD_byte(bdata), .LD_byte_ready(ready),
    .IMEM_address(addr), .IMEM_data(data), .IMEM_wren(wren), .LD_busy(busy),
    .LD_cpu_hold(hold), .LD_done(done), .LD_error(err), .LD_words_loaded(wl));

  imem_loader #(.ADDR_W(8), .TIMEOUT(1023), .BIG_ENDIAN(1'b0)) dut_le (
    .SYS_clk(clk), .SYS_reset(rst), .LD_start(start), .LD_word_count(count),
    .LD_byte_valid(valid), .LD_byte(bdata), .LD_byte_ready(le_ready),
    .IMEM_address(le_addr), .IMEM_data(le_data), .IMEM_wren(le_wren), .LD_busy(le_busy),
    .LD_cpu_hold(le_hold), .LD_done(le_done), .LD_error(le_err), .LD_words_loaded(le_wl));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wren) begin
      wr_addr.push_back(addr);
      wr_data.push_back(data);
      if (ready) rdy_in_write++;
    end
    if (le_wren) le_wr_data.push_back(le_data);
  end

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wr_addr.delete(); wr_data.delete(); le_wr_data.delete(); rdy_in_write = 0;
  endtask

  task automatic do_start(input logic [7:0] c);
    start = 1'b1; count = c;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    valid = 1'b1; bdata = b;
    @(negedge clk);
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      errors++;
      $display("FAIL send_byte_timeout: ready=%0b required 1 for byte %h", ready, b);
    end
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({ready, wren, busy, hold, done, err} !== 6'b0 || addr !== 32'h0 || data !== 32'h0 || wl !== 8'h0) begin
      errors++;
      $display("FAIL reset_outputs: flags=%b addr=%h data=%h wl=%0d required all zero",
               {ready, wren, busy, hold, done, err}, addr, data, wl);
    end
    do_reset();
  endtask

  task automatic test_basic_load();
    logic [7:0] bytes [8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
    do_reset();
    do_start(8'd2);
    checks++;
    if (busy !== 1'b1 || hold !== 1'b1) begin
      errors++; $display("FAIL basic_busy: busy=%b hold=%b required 1 1", busy, hold);
    end
    foreach (bytes[i]) send_byte(bytes[i]);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || hold !== 1'b1 || wl !== 8'd2) begin
      errors++; $display("FAIL basic_done: done=%b hold=%b wl=%0d required 1 1 2", done, hold, wl);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || hold !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_release: done=%b hold=%b busy=%b required 0 0 0", done, hold, busy);
    end
    checks++;
    if (wr_data.size() != 2) begin
      errors++; $display("FAIL basic_wcount: writes=%0d required 2", wr_data.size());
    end else if (wr_addr[0] !== 32'd0 || wr_data[0] !== 32'h20080005 ||
                 wr_addr[1] !== 32'd1 || wr_data[1] !== 32'h8C090004) begin
      errors++;
      $display("FAIL basic_words: (%0d,%h) (%0d,%h) required (0,20080005) (1,8c090004)",
               wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
    end
  endtask

  task automatic test_little_endian();
    logic [7:0] bytes [4] = '{8'h05, 8'h00, 8'h08, 8'h20};
    do_reset();
    valid = 1'b1; bdata = 8'hAA;
    repeat (3) @(negedge clk);
    checks++;
    if (ready !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_ignore: ready=%b busy=%b required 0 0", ready, busy);
    end
    valid = 1'b0;
    do_start(8'd1);
    foreach (bytes[i]) send_byte(bytes[i]);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (le_wr_data.size() != 1 || le_done !== 1'b1) begin
      errors++; $display("FAIL le_wcount: writes=%0d done=%b required 1 1", le_wr_data.size(), le_done);
    end else if (le_wr_data[0] !== 32'h20080005) begin
      errors++; $display("FAIL le_word: data=%h required 20080005", le_wr_data[0]);
    end
    checks++;
    if (wr_data.size() != 1) begin
      errors++; $display("FAIL be_wcount: writes=%0d required 1", wr_data.size());
    end else if (wr_data[0] !== 32'h05000820) begin
      errors++; $display("FAIL be_word: data=%h required 05000820", wr_data[0]);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    do_start(8'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (7) @(posedge clk);
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL tmo_early: err=%b busy=%b required 0 1 after 7 idle cycles", err, busy);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || hold !== 1'b1 || busy !== 1'b0 || wr_data.size() != 0) begin
      errors++;
      $display("FAIL tmo_error: err=%b hold=%b busy=%b writes=%0d required 1 1 0 0",
               err, hold, busy, wr_data.size());
    end
    repeat (3) @(negedge clk);
    checks++;
    if (err !== 1'b1 || hold !== 1'b1) begin
      errors++; $display("FAIL tmo_sticky: err=%b hold=%b required 1 1", err, hold);
    end
    do_start(8'd1);
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1 || hold !== 1'b1) begin
      errors++; $display("FAIL tmo_restart: err=%b busy=%b hold=%b required 0 1 1", err, busy, hold);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    do_start(8'd3);
    for (int i = 0; i < 12; i++) begin
      send_byte(8'h10 + 8'(i));
      if (i == 5) begin
        start = 1'b1; count = 8'd5;
        @(posedge clk);
        #1 start = 1'b0;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || wl !== 8'd3) begin
      errors++; $display("FAIL b2b_done: done=%b wl=%0d required 1 3", done, wl);
    end
    checks++;
    if (rdy_in_write != 0) begin
      errors++; $display("FAIL b2b_ready_in_write: count=%0d required 0", rdy_in_write);
    end
    checks++;
    if (wr_data.size() != 3) begin
      errors++; $display("FAIL b2b_wcount: writes=%0d required 3", wr_data.size());
    end else if (wr_addr[0] !== 32'd0 || wr_addr[1] !== 32'd1 || wr_addr[2] !== 32'd2 ||
                 wr_data[0] !== 32'h10111213 || wr_data[1] !== 32'h14151617 ||
                 wr_data[2] !== 32'h18191A1B) begin
      errors++;
      $display("FAIL b2b_words: %0d:%h %0d:%h %0d:%h required 0:10111213 1:14151617 2:18191a1b",
               wr_addr[0], wr_data[0], wr_addr[1], wr_data[1], wr_addr[2], wr_data[2]);
    end
  endtask

  task automatic test_reset_midload();
    logic [7:0] bytes [6] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09};
    do_reset();
    do_start(8'd2);
    foreach (bytes[i]) send_byte(bytes[i]);
    rst = 1'b1;
    #1;
    checks++;
    if ({ready, wren, busy, hold, done, err} !== 6'b0 || wl !== 8'h0 || addr !== 32'h0 || data !== 32'h0) begin
      errors++;
      $display("FAIL midload_reset: flags=%b wl=%0d addr=%h data=%h required all zero",
               {ready, wren, busy, hold, done, err}, wl, addr, data);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (wr_data.size() != 1) begin
      errors++; $display("FAIL midload_wcount: writes=%0d required 1", wr_data.size());
    end else if (wr_data[0] !== 32'h20080005) begin
      errors++; $display("FAIL midload_word0: data=%h required 20080005", wr_data[0]);
    end
    do_start(8'd0);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || hold !== 1'b1) begin
      errors++; $display("FAIL zero_done: done=%b busy=%b hold=%b required 1 0 1", done, busy, hold);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || hold !== 1'b0 || wl !== 8'd0 || wr_data.size() != 1) begin
      errors++;
      $display("FAIL zero_after: done=%b hold=%b wl=%0d writes=%0d required 0 0 0 1",
               done, hold, wl, wr_data.size());
    end
  endtask

`ifdef LD_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] bytes [4] = '{8'h01, 8'h02, 8'h04, 8'h08};
    do_reset();
    do_start(8'd1);
    foreach (bytes[i]) send_byte(bytes[i]);
    send_byte(8'h0F);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL csum_good: done=%b err=%b required 1 0", done, err);
    end
    do_reset();
    do_start(8'd1);
    foreach (bytes[i]) send_byte(bytes[i]);
    send_byte(8'h0E);
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || hold !== 1'b1) begin
      errors++; $display("FAIL csum_bad: err=%b done=%b hold=%b required 1 0 1", err, done, hold);
    end
    checks++;
    if (wr_data.size() != 1) begin
      errors++; $display("FAIL csum_wcount: writes=%0d required 1", wr_data.size());
    end else if (wr_data[0] !== 32'h01020408) begin
      errors++; $display("FAIL csum_word: data=%h required 01020408", wr_data[0]);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_load();
    test_little_endian();
    test_timeout();
    test_back_to_back();
    test_reset_midload();
`ifdef LD_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
